// File: rtl/ann_seq_pkg.sv
// ann_seq_pkg: shared types and constants for the drowsiness ANN frame sequencer.
package ann_seq_pkg;

    // Default datapath geometry of the drowsiness detector.
    localparam int DEF_N_FEAT   = 30;
    localparam int DEF_DW       = 10;
    localparam int DEF_N_OUT    = 3;
    localparam int DEF_WDOG_CYC = 4095;

    // Sequencer states; encodings are visible on the LEDR debug port.
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_ERR   = 3'd4
    } seq_state_t;

    // Classification indices produced by the argmax.
    localparam logic [1:0] CLS_ALERT  = 2'd0;
    localparam logic [1:0] CLS_DROWSY = 2'd1;
    localparam logic [1:0] CLS_ASLEEP = 2'd2;

    // Anything other than "alert" counts as drowsy for the summary flag.
    function automatic logic cls_is_drowsy(input logic [1:0] cls);
        return cls != CLS_ALERT;
    endfunction

endpackage

// File: rtl/ann_argmax.sv
// ann_argmax: combinational unsigned argmax over N_OUT packed scores.
// Ties go to the lowest index, so equal scores report index 0.
module ann_argmax
    import ann_seq_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int DW    = DEF_DW,
    parameter int IW    = 2
) (
    input  logic [N_OUT*DW-1:0] scores,
    output logic [IW-1:0]       idx,
    output logic [DW-1:0]       score
);

    // Linear scan; strict greater-than keeps the earliest maximum on ties.
    always_comb begin
        idx   = '0;
        score = scores[DW-1:0];
        for (int i = 1; i < N_OUT; i++) begin
            if (scores[i*DW +: DW] > score) begin
                idx   = IW'(i);
                score = scores[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/ann_frame_sequencer.sv
// ann_frame_sequencer: gathers one feature frame from a valid/ready stream,
// runs the drowsiness detector once over it and presents the argmax result
// on a valid/ready port.
// Build option: define ANN_SEQ_WDOG_EN to add a WAIT watchdog that parks the
// FSM in ERR and raises a sticky err flag; otherwise WAIT waits forever.
module ann_frame_sequencer
    import ann_seq_pkg::*;
#(
    parameter int N_FEAT   = DEF_N_FEAT,
    parameter int DW       = DEF_DW,
    parameter int N_OUT    = DEF_N_OUT,
    parameter int WDOG_CYC = DEF_WDOG_CYC
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 flush,
    input  logic                 feat_valid,
    input  logic [DW-1:0]        feat_data,
    output logic                 feat_ready,
    output logic [N_FEAT*DW-1:0] ann_in,
    output logic                 ann_start,
    input  logic                 ann_done,
    input  logic [N_OUT*DW-1:0]  ann_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_class,
    output logic [DW-1:0]        res_score,
    output logic                 res_drowsy,
    output logic [2:0]           state_o,
    output logic                 err
);

    localparam int              CW       = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N_FEAT - 1);

    seq_state_t                  state;
    logic [CW-1:0]               cnt;
    logic [N_FEAT-1:0][DW-1:0]   feat_buf;
    logic [1:0]                  max_idx;
    logic [DW-1:0]               max_score;

`ifdef ANN_SEQ_WDOG_EN
    localparam int              WW      = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0]   WD_LAST = WW'(WDOG_CYC - 1);
    logic [WW-1:0]               wd_cnt;
`else
    assign err = 1'b0;
`endif

    // Only LOAD accepts beats; flush blocks the beat it coincides with, and
    // the port stays closed while reset is held.
    assign feat_ready = Rst && (state == S_LOAD) && !flush;
    assign ann_in     = feat_buf;
    assign state_o    = state;

    ann_argmax #(
        .N_OUT (N_OUT),
        .DW    (DW),
        .IW    (2)
    ) u_argmax (
        .scores (ann_out),
        .idx    (max_idx),
        .score  (max_score)
    );

    // Sequencer FSM with registered start pulse, result and error outputs.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state      <= S_LOAD;
            cnt        <= '0;
            feat_buf   <= '0;
            ann_start  <= 1'b0;
            res_valid  <= 1'b0;
            res_class  <= CLS_ALERT;
            res_score  <= '0;
            res_drowsy <= 1'b0;
`ifdef ANN_SEQ_WDOG_EN
            wd_cnt     <= '0;
            err        <= 1'b0;
`endif
        end else if (flush) begin
            // Abort: drop the partial frame and any pending result. The buffer
            // keeps stale data; the next frame overwrites it from index 0.
            // A start already on the wire in START still completes its cycle.
            state     <= S_LOAD;
            cnt       <= '0;
            ann_start <= 1'b0;
            res_valid <= 1'b0;
`ifdef ANN_SEQ_WDOG_EN
            wd_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            ann_start <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (feat_valid) begin
                        feat_buf[cnt] <= feat_data;
                        if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            state     <= S_START;
                            ann_start <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
`ifdef ANN_SEQ_WDOG_EN
                    wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (ann_done) begin
                        res_class  <= max_idx;
                        res_score  <= max_score;
                        res_drowsy <= cls_is_drowsy(max_idx);
                        res_valid  <= 1'b1;
                        state      <= S_EMIT;
                    end
`ifdef ANN_SEQ_WDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
`ifdef ANN_SEQ_WDOG_EN
                S_ERR: begin
                    state <= S_ERR;
                end
`endif
                default: begin
                    state <= S_LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ann_frame_sequencer.sv
// tb_ann_frame_sequencer: randomized self-checking bench for ann_frame_sequencer
// with a latency-programmable detector model and an argmax reference.
module tb_ann_frame_sequencer;

    localparam int N_FEAT = 30;
    localparam int DW     = 10;
    localparam int N_OUT  = 3;
`ifdef ANN_SEQ_WDOG_EN
    localparam int WDOG   = 50;
`else
    localparam int WDOG   = 4095;
`endif

    logic                 Clock = 1'b0;
    logic                 Rst   = 1'b1;
    logic                 flush = 1'b0;
    logic                 feat_valid = 1'b0;
    logic [DW-1:0]        feat_data  = '0;
    logic                 feat_ready;
    logic [N_FEAT*DW-1:0] ann_in;
    logic                 ann_start;
    logic                 ann_done = 1'b0;
    logic [N_OUT*DW-1:0]  ann_out  = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [1:0]           res_class;
    logic [DW-1:0]        res_score;
    logic                 res_drowsy;
    logic [2:0]           state_o;
    logic                 err;

    ann_frame_sequencer #(
        .N_FEAT (N_FEAT), .DW (DW), .N_OUT (N_OUT), .WDOG_CYC (WDOG)
    ) dut (
        .Clock (Clock), .Rst (Rst), .flush (flush),
        .feat_valid (feat_valid), .feat_data (feat_data), .feat_ready (feat_ready),
        .ann_in (ann_in), .ann_start (ann_start), .ann_done (ann_done), .ann_out (ann_out),
        .res_valid (res_valid), .res_ready (res_ready), .res_class (res_class),
        .res_score (res_score), .res_drowsy (res_drowsy), .state_o (state_o), .err (err)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    int frm[N_FEAT];
    bit det_en = 1'b1;
    int det_lat = 20;
    logic [N_OUT*DW-1:0] det_q[$];
    logic [N_OUT*DW-1:0] det_cur;
    int  det_cnt = 0;
    bit  det_busy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N_OUT*DW-1:0] mk_sc(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    // Reference: highest value first, then the first index that holds it.
    function automatic int ref_max(input logic [N_OUT*DW-1:0] v);
        int m = 0;
        for (int i = 0; i < N_OUT; i++) m = (int'(v[i*DW +: DW]) > m) ? int'(v[i*DW +: DW]) : m;
        return m;
    endfunction

    function automatic int ref_cls(input logic [N_OUT*DW-1:0] v);
        for (int i = 0; i < N_OUT; i++) if (int'(v[i*DW +: DW]) == ref_max(v)) return i;
        return 0;
    endfunction

    function automatic logic [N_FEAT*DW-1:0] frm_flat();
        logic [N_FEAT*DW-1:0] f = '0;
        for (int i = 0; i < N_FEAT; i++) f[i*DW +: DW] = DW'(frm[i]);
        return f;
    endfunction

    // Detector model: done pulses det_lat cycles after the start it saw.
    always @(negedge Clock) begin
        if (!Rst) begin
            det_busy = 1'b0;
            ann_done = 1'b0;
        end else begin
            ann_done = 1'b0;
            if (det_busy) begin
                det_cnt--;
                if (det_cnt == 0) begin
                    ann_done = 1'b1;
                    ann_out  = det_cur;
                    det_busy = 1'b0;
                end
            end
            if (ann_start) begin
                n_start++;
                if (det_en) begin
                    det_cur  = (det_q.size() > 0) ? det_q.pop_front() : '0;
                    det_cnt  = det_lat;
                    det_busy = 1'b1;
                end
            end
        end
    end

    task automatic send_beat(input int v, input string tag);
        int n = 0;
        feat_valid = 1'b1;
        feat_data  = DW'(v);
        while (!feat_ready && n < 300) begin @(negedge Clock); n++; end
        if (n >= 300) chk({tag, "_rdy_timeout"}, feat_ready, 1);
        @(negedge Clock);
        feat_valid = 1'b0;
    endtask

    // Streams frm[], then checks the start pulse and the frame handed over.
    task automatic send_frame(input int gap, input string tag);
        for (int i = 0; i < N_FEAT; i++) begin
            repeat ($urandom_range(0, gap)) @(negedge Clock);
            send_beat(frm[i], tag);
        end
        chk({tag, "_start"}, ann_start, 1);
        for (int i = 0; i < N_FEAT; i++) chk({tag, "_ann_in"}, ann_in[i*DW +: DW], frm[i]);
    endtask

    task automatic wait_res(input string tag, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 500) begin @(negedge Clock); cyc++; end
        chk({tag, "_res_valid"}, res_valid, 1);
    endtask

    task automatic check_res(input string tag, input logic [N_OUT*DW-1:0] sc);
        chk({tag, "_class"}, res_class, ref_cls(sc));
        chk({tag, "_score"}, res_score, ref_max(sc));
        chk({tag, "_drowsy"}, res_drowsy, ref_cls(sc) != 0);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge Clock);
        res_ready = 1'b0;
        #1;
        chk({tag, "_hs_rdy"}, feat_ready, 1);
        chk({tag, "_hs_valid"}, res_valid, 0);
        chk({tag, "_hs_state"}, state_o, 0);
    endtask

    function automatic logic [N_OUT*DW-1:0] rnd_sc();
        return mk_sc($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N_OUT*DW-1:0] sc;
        logic [N_OUT*DW-1:0] exp_q[$];
        int cyc, s0, n;
        int fr[3][N_FEAT];

        // Reset values
        #1 Rst = 1'b0;
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_ann_in_zero", ann_in == '0, 1);
        chk("rst_outs", {ann_start, res_valid, res_class, res_score, res_drowsy, err}, 0);
        chk("rst_feat_ready", feat_ready, 0);
        repeat (2) @(negedge Clock);
        Rst = 1'b1;
        #1 chk("rst_rel_ready", feat_ready, 1);

        // Full frame: i*7, scores {50,900,120}, 20-cycle detector
        for (int i = 0; i < N_FEAT; i++) frm[i] = i * 7;
        sc = mk_sc(50, 900, 120);
        det_q.push_back(sc);
        s0 = n_start;
        send_frame(2, "full");
        wait_res("full", cyc);
        chk("full_latency", cyc, det_lat + 1);
        chk("full_one_start", n_start - s0, 1);
        check_res("full", sc);
        chk("full_class_const", res_class, 1);
        chk("full_score_const", res_score, 900);
        handshake("full");

        // Tie with 10 cycles of backpressure
        for (int i = 0; i < N_FEAT; i++) frm[i] = $urandom_range(0, 1023);
        sc = mk_sc(300, 300, 300);
        det_q.push_back(sc);
        send_frame(1, "tie");
        wait_res("tie", cyc);
        for (int c = 0; c < 10; c++) begin
            chk("tie_hold", {res_valid, feat_ready, res_class, res_score, res_drowsy},
                {1'b1, 1'b0, 2'd0, 10'd300, 1'b0});
            chk("tie_ann_in_stable", ann_in == frm_flat(), 1);
            @(negedge Clock);
        end
        handshake("tie");

        // Flush mid-load; the coinciding 0x3FF beat must be dropped
        for (int i = 0; i < 12; i++) send_beat($urandom_range(0, 1023), "fl_pre");
        feat_valid = 1'b1;
        feat_data  = 10'h3FF;
        flush      = 1'b1;
        #1 chk("fl_ready_low", feat_ready, 0);
        @(negedge Clock);
        flush      = 1'b0;
        feat_valid = 1'b0;
        #1;
        chk("fl_state", state_o, 0);
        chk("fl_ready_back", feat_ready, 1);
        for (int i = 0; i < N_FEAT; i++) frm[i] = 200;
        sc = rnd_sc();
        det_q.push_back(sc);
        send_frame(1, "fl");
        wait_res("fl", cyc);
        check_res("fl", sc);
        handshake("fl");

        // Async reset while waiting for the detector
        det_en = 1'b0;
        for (int i = 0; i < N_FEAT; i++) frm[i] = $urandom_range(1, 1023);
        send_frame(1, "ar");
        repeat (5) @(negedge Clock);
        chk("ar_in_wait", state_o, 2);
        #2 Rst = 1'b0;
        #1;
        chk("ar_res_valid", res_valid, 0);
        chk("ar_state", state_o, 0);
        chk("ar_ann_in_zero", ann_in == '0, 1);
        repeat (2) @(negedge Clock);
        Rst = 1'b1;
        det_en = 1'b1;
        #1 chk("ar_ready", feat_ready, 1);
        for (int i = 0; i < N_FEAT; i++) frm[i] = $urandom_range(0, 1023);
        sc = rnd_sc();
        det_q.push_back(sc);
        send_frame(0, "ar2");
        wait_res("ar2", cyc);
        check_res("ar2", sc);
        handshake("ar2");

        // Detector never answers
        det_en = 1'b0;
        for (int i = 0; i < N_FEAT; i++) frm[i] = $urandom_range(0, 1023);
        send_frame(0, "wd");
`ifdef ANN_SEQ_WDOG_EN
        repeat (WDOG - 6) @(negedge Clock);
        chk("wd_still_wait", {state_o, err}, {3'd2, 1'b0});
        n = 0;
        while (!err && n < 20) begin @(negedge Clock); n++; end
        chk("wd_err", err, 1);
        chk("wd_state_err", state_o, 4);
        chk("wd_ready_low", feat_ready, 0);
        repeat (3) @(negedge Clock);
        chk("wd_err_sticky", err, 1);
`else
        repeat (60) @(negedge Clock);
        chk("wd_waits", state_o, 2);
        chk("wd_err_tied", err, 0);
`endif
        flush = 1'b1;
        @(negedge Clock);
        flush = 1'b0;
        #1;
        chk("wd_flush_err", err, 0);
        chk("wd_flush_state", state_o, 0);
        chk("wd_flush_ready", feat_ready, 1);
        det_en = 1'b1;

        // Back-to-back frames with res_ready high
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N_FEAT; i++) fr[f][i] = $urandom_range(0, 1023);
            sc = rnd_sc();
            det_q.push_back(sc);
            exp_q.push_back(sc);
        end
        res_ready = 1'b1;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    frm = fr[f];
                    send_frame(0, "b2b");
                end
            end
            begin
                int got = 0;
                int c = 0;
                while (got < 3 && c < 3000) begin
                    @(negedge Clock);
                    c++;
                    if (res_valid) begin
                        check_res("b2b", exp_q.pop_front());
                        got++;
                        @(negedge Clock);
                        c++;
                        chk("b2b_ready_after_hs", feat_ready, 1);
                    end
                end
                chk("b2b_results", got, 3);
            end
        join
        res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ann_frame_sequencer.md
# ann_frame_sequencer

Controller that sequences the drowsiness ANN datapath. It collects one 30-feature frame from a streaming source into a local register bank. It then pulses the detector's start, waits for completion, and latches the 3 class scores. Finally it presents an argmax classification on a valid/ready result port. It sits between the feature-extraction front end and the `DrowsinessDetector` core, and replaces the switch-driven static feature arrays used for board bring-up.

## Interface
- `N_FEAT`, 30: features per frame.
- `DW`, 10: feature and score width (unsigned).
- `N_OUT`, 3: ANN output scores.
- `WDOG_CYC`, 4095: maximum cycles spent in WAIT (used only with the watchdog build).

- `Clock` in 1: single clock for the whole block.
- `Rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous abort. Discards the partial frame and any pending result.
- `feat_valid` in 1, `feat_data` in DW, `feat_ready` out 1: feature stream. One feature per accepted beat, in index order 0..N_FEAT-1.
- `ann_in` out N_FEAT*DW: flattened frame to the detector. Feature i occupies `[i*DW +: DW]`.
- `ann_start` out 1: one-cycle start pulse to the detector.
- `ann_done` in 1: detector completion. Level or pulse; sampled only in WAIT.
- `ann_out` in N_OUT*DW: detector scores, valid in the cycle `ann_done`=1.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_class` out 2: argmax index. 0=alert, 1=drowsy, 2=asleep.
- `res_score` out DW: winning score.
- `res_drowsy` out 1: `res_class`!=0.
- `state_o` out 3: FSM encoding, for LEDR debug.
- `err` out 1: sticky watchdog flag.

## Operation
- FSM states: LOAD=0, START=1, WAIT=2, EMIT=3, plus ERR=4 (watchdog build only).
- **LOAD:** `feat_ready` = (state==LOAD) && !`flush`.
  - On each accepted beat: `buf[cnt]` <= `feat_data`, `cnt`++.
  - Accepting the beat at `cnt`==N_FEAT-1 moves to START and clears `cnt` to 0.
- **START:** `ann_start`=1 for exactly this cycle, then the FSM goes to WAIT unconditionally.
- **WAIT:** on `ann_done`=1, the block latches the argmax of `ann_out` into `res_class`/`res_score`/`res_drowsy` and goes to EMIT.
- **EMIT:** `res_valid`=1, and the result registers hold stable. When `res_valid`&&`res_ready`, the FSM returns to LOAD.
- **Buffer write rule:** `buf` is written only in LOAD. `ann_in` is therefore stable from START through the end of EMIT.
- **Argmax:** unsigned compare. Ties resolve to the lowest index, so all-equal scores give class 0.
- **`flush`:** in any state, the next state is LOAD, `cnt`=0, and `res_valid` drops.
  - `buf` contents are kept but will be overwritten.
  - If `flush` and `feat_valid` are asserted in the same cycle, `flush` wins and the beat is not accepted.
  - If `flush` is asserted in START, `ann_start` still pulses that cycle. The detector result is then ignored.
- **`ann_done` outside WAIT:** ignored.
- **`feat_valid` outside LOAD:** stalled, because `feat_ready`=0.

## Timing
- **Reset values (asynchronous, `Rst`=0):**
  - state=LOAD, `cnt`=0, `buf`=0, so `ann_in`=0.
  - `ann_start`=0, `res_valid`=0, `res_class`=0, `res_score`=0, `res_drowsy`=0, `err`=0, `state_o`=0.
  - `feat_ready` goes to 1 combinationally once `Rst` is released.
- **Reset mid-frame or mid-WAIT:** all progress is lost. After release, the block restarts at LOAD with feature index 0.
- **Last feature to start:** the last feature is accepted at edge k, and `ann_start` is high in cycle k+1.
- **Done to result:** `ann_done` is sampled at edge m, and `res_valid` is high from cycle m+1.
- **Result to next frame:** the handshake completes at edge r, and `feat_ready`=1 in cycle r+1.
- **Minimum frame period:** N_FEAT + 3 + detector latency cycles.

## Configuration
- **`ANN_SEQ_WDOG_EN` defined:**
  - A counter runs in WAIT. If it reaches WDOG_CYC without `ann_done`, the FSM goes to ERR and sets `err`=1.
  - ERR holds `feat_ready`=0.
  - Only `flush` or reset exits ERR, returning to LOAD. `flush` clears `err`; `err` is otherwise sticky.
- **Undefined:** there is no counter and no ERR state, `err` is tied to 0, and WAIT waits indefinitely.

## Structure
- **Package `ann_seq_pkg`:**
  - `seq_state_t` enum with explicit 3-bit encodings.
  - Class constants CLS_ALERT=0, CLS_DROWSY=1, CLS_ASLEEP=2.
  - Default widths DW=10 and N_FEAT=30.
- **Sub-module `ann_argmax`:** combinational, N_OUT×DW in, index and score out, lowest-index tie rule. It is instantiated once.

## Test plan
- **Full frame:**
  - Stimulus: 30 beats with `feat_data`=i*7; the detector model asserts `ann_done` 20 cycles after start with scores {50, 900, 120}.
  - Required: exactly one `ann_start` pulse, `ann_in[i]`=i*7, then `res_class`=1, `res_score`=900, `res_drowsy`=1.
- **Tie and backpressure:**
  - Stimulus: scores {300, 300, 300}, with `res_ready` held low for 10 cycles.
  - Required: `res_class`=0 and `res_drowsy`=0, result registers stable for all 10 cycles, `feat_ready`=0 throughout.
- **Flush mid-load:**
  - Stimulus: 12 beats, then `flush` coinciding with a beat of value 0x3FF, then a full frame of 200s.
  - Required: the 0x3FF beat is not stored, and all `ann_in` = 200 when `ann_start` pulses.
- **Async reset in WAIT:**
  - Stimulus: `Rst`=0 mid-WAIT.
  - Required: `res_valid`=0, `state_o`=0, `ann_in`=0 immediately. After release, `feat_ready`=1 and index 0 is the next feature loaded.
- **Watchdog (`ANN_SEQ_WDOG_EN`, WDOG_CYC=50):**
  - Stimulus: no `ann_done`, then `flush`.
  - Required: `err`=1 and `state_o`=4 at cycle 50 of WAIT. After `flush`, `err`=0 and `state_o`=0.
- **Back-to-back frames:**
  - Stimulus: `res_ready` tied high, 3 frames streamed continuously.
  - Required: 3 results in order, with `feat_ready` reasserted one cycle after each handshake.
